fdiv_seq: RTL and testbench

Programmable clock-enable sequencer for the divider datapath. It accepts a command (divisor N, tick count K) over a valid/ready handshake and advances an internal phase counter on each enabled cycle. It emits a one-cycle `tick` every N enabled cycles, K times in total, and then pulses `done`. It sits between the control logic and any consumer of divided clock enables, generalising the fixed divide-by-3 FSM to runtime-selected ratios with burst length and abort.

---
 rtl/fdiv_seq.sv | 124 ++++++++++++
 tb/tb_fdiv_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// Clock-enable sequencer: one registered tick every N enabled cycles, K times, then a done pulse.
// Commands use valid/ready (ready only in IDLE); FDIV_SEQ_RELOAD_EN makes bursts repeat until abort.
module fdiv_seq #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             c_up,
  input  logic             abort,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ticks_left
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam logic [DIV_W-1:0] ONE_D = DIV_W'(1);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] phase, phase_nxt;
  logic [DIV_W-1:0] div_r, div_nxt;
  logic [CNT_W-1:0] left_r, left_nxt;
  logic             tick_r, tick_nxt;
`ifdef FDIV_SEQ_RELOAD_EN
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
`endif

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    div_nxt   = div_r;
    left_nxt  = left_r;
    tick_nxt  = 1'b0;
`ifdef FDIV_SEQ_RELOAD_EN
    cnt_nxt   = cnt_r;
`endif
    if (abort) begin
      state_nxt = IDLE;
      phase_nxt = '0;
      left_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            div_nxt   = (cmd_div == '0) ? ONE_D : cmd_div;
            left_nxt  = cmd_cnt;
            phase_nxt = '0;
`ifdef FDIV_SEQ_RELOAD_EN
            cnt_nxt   = cmd_cnt;
`endif
            state_nxt = (cmd_cnt != '0) ? RUN : DONE;
          end
        end
        RUN: begin
          if (c_up) begin
            // Phase wraps at div_r-1, so it can never overflow DIV_W bits.
            if (phase == div_r - ONE_D) begin
              phase_nxt = '0;
              tick_nxt  = 1'b1;
              if (left_r != '0) left_nxt = left_r - ONE_C;
              if (left_r == ONE_C) state_nxt = DONE;
            end else begin
              phase_nxt = phase + ONE_D;
            end
          end
        end
        DONE: begin
`ifdef FDIV_SEQ_RELOAD_EN
          if (cnt_r != '0) begin
            state_nxt = RUN;
            left_nxt  = cnt_r;
            phase_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      phase  <= '0;
      div_r  <= ONE_D;
      left_r <= '0;
      tick_r <= 1'b0;
`ifdef FDIV_SEQ_RELOAD_EN
      cnt_r  <= '0;
`endif
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      div_r  <= div_nxt;
      left_r <= left_nxt;
      tick_r <= tick_nxt;
`ifdef FDIV_SEQ_RELOAD_EN
      cnt_r  <= cnt_nxt;
`endif
    end
  end

  assign cmd_ready  = (state == IDLE) & ~abort;
  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign tick       = tick_r;
  assign ticks_left = left_r;

endmodule

// File: tb/tb_fdiv_seq.sv
// Scoreboard bench for fdiv_seq: expected tick/done events are queued at command time and matched on output.
module tb_fdiv_seq;

  logic       clk;
  logic       rst_b;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_div;
  logic [7:0] cmd_cnt;
  logic       c_up;
  logic       abort;
  logic       tick;
  logic       busy;
  logic       done;
  logic [7:0] ticks_left;

  typedef struct {
    int cyc;
    int tck;
    int dn;
    int left;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  int  e0;

  fdiv_seq #(.DIV_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_div    (cmd_div),
    .cmd_cnt    (cmd_cnt),
    .c_up       (c_up),
    .abort      (abort),
    .tick       (tick),
    .busy       (busy),
    .done       (done),
    .ticks_left (ticks_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d events still pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input int t, input int d, input int l);
    ev_t e;
    e.cyc = c; e.tck = t; e.dn = d; e.left = l;
    exp_q.push_back(e);
  endtask

  // Every observed tick/done cycle must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst_b === 1'b1 && (tick === 1'b1 || done === 1'b1)) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_tick_done", 32'({tick, done}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ev_cycle", cyc, e.cyc);
        check_eq("ev_tick", 32'(tick), e.tck);
        check_eq("ev_done", 32'(done), e.dn);
        check_eq("ev_ticks_left", 32'(ticks_left), e.left);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called between a negedge and the next posedge; returns at the negedge after acceptance.
  task automatic send(input int dv, input int cnt, input bit auto_push, output int acc);
    int n;
    cmd_div   = dv[7:0];
    cmd_cnt   = cnt[7:0];
    cmd_valid = 1'b1;
    #1;
    check_eq("ready_before_accept", 32'(cmd_ready), 32'd1);
    acc = cyc + 1;
    n = (dv == 0) ? 1 : dv;
    if (auto_push) begin
      if (cnt == 0) push_ev(acc, 0, 1, 0);
      for (int i = 1; i <= cnt; i++) push_ev(acc + i * n, 1, (i == cnt) ? 1 : 0, cnt - i);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("ticks_left_loaded", 32'(ticks_left), cnt);
    check_eq("busy_after_accept", 32'(busy), (cnt != 0) ? 1 : 0);
  endtask

  task automatic drain(input string tag);
    #1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check_eq(tag, exp_q.size(), 0);
    @(negedge clk);
    check_eq("ready_after_burst", 32'(cmd_ready), 32'd1);
    check_eq("busy_after_burst", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_b = 1'b0; cmd_valid = 1'b0; cmd_div = '0; cmd_cnt = '0; c_up = 1'b1; abort = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_tick", 32'(tick), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ticks_left", 32'(ticks_left), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // K=0: no ticks, done visible in the cycle after acceptance
    send(4, 0, 1'b1, e0);
    drain("k0_drain");

`ifndef FDIV_SEQ_RELOAD_EN
    // divide-by-3 burst of 4
    send(3, 4, 1'b1, e0);
    drain("div3_drain");

    // N=0 treated as N=1: three back-to-back ticks
    send(0, 3, 1'b1, e0);
    drain("div0_drain");

    // enable gating: two low c_up cycles between ticks stretch spacing to 5
    send(3, 2, 1'b0, e0);
    push_ev(e0 + 3, 1, 0, 1);
    push_ev(e0 + 8, 1, 1, 0);
    wait_cyc(e0 + 4);
    c_up = 1'b0;
    wait_cyc(e0 + 6);
    check_eq("gate_ticks_left_hold", 32'(ticks_left), 32'd1);
    check_eq("gate_busy", 32'(busy), 32'd1);
    c_up = 1'b1;
    drain("gate_drain");
`else
    // repeating bursts: N=2, K=3 gives done every 7 cycles
    send(2, 3, 1'b0, e0);
    for (int b = 0; b < 3; b++)
      for (int i = 1; i <= 3; i++)
        push_ev(e0 + 7 * b + 2 * i, 1, (i == 3) ? 1 : 0, 3 - i);
    wait_cyc(e0 + 7);
    check_eq("reload_ticks_left", 32'(ticks_left), 32'd3);
    check_eq("reload_busy", 32'(busy), 32'd1);
    check_eq("reload_ready_low", 32'(cmd_ready), 32'd0);
    wait_cyc(e0 + 20);
    check_eq("reload_done_ready_low", 32'(cmd_ready), 32'd0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check_eq("reload_abort_ready", 32'(cmd_ready), 32'd1);
    check_eq("reload_abort_left", 32'(ticks_left), 32'd0);
    drain("reload_drain");
`endif

    // abort after the 2nd tick; a command held alongside abort must be ignored
    send(5, 10, 1'b0, e0);
    push_ev(e0 + 5, 1, 0, 9);
    push_ev(e0 + 10, 1, 0, 8);
    wait_cyc(e0 + 10);
    abort = 1'b1; cmd_valid = 1'b1; cmd_div = 8'd1; cmd_cnt = 8'd0;
    #1;
    check_eq("ready_during_abort", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ticks_left", 32'(ticks_left), 32'd0);
    check_eq("abort_tick", 32'(tick), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("abort_cmd_ignored_busy", 32'(busy), 32'd0);
    check_eq("abort_cmd_ignored_done", 32'(done), 32'd0);
    abort = 1'b0; cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    drain("abort_drain");

    // asynchronous reset mid-burst
    send(2, 5, 1'b0, e0);
    push_ev(e0 + 2, 1, 0, 4);
    wait_cyc(e0 + 3);
    #2 rst_b = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_ticks_left", 32'(ticks_left), 32'd0);
    check_eq("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (6) @(negedge clk);
    drain("arst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
